// File: rtl/debounce_gate_if.sv
// Purpose : bundles the raw input and conditioned outputs of debounce_gate.
// Ports   : a (raw async level in), out (clean level), rise/fall (1-cycle
//           edge pulses), busy (transition being qualified), glitch_cnt.
// master = the side that drives `a` and consumes the results; slave = debounce_gate.
interface debounce_gate_if;
  logic       a;
  logic       out;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (
    output a,
    input  out, rise, fall, busy, glitch_cnt
  );

  modport slave (
    input  a,
    output out, rise, fall, busy, glitch_cnt
  );
endinterface

// File: rtl/debounce_gate.sv
// Purpose : synchronise and debounce a raw async bit into a clean level for a downstream gate.
// Latency : out flips on edge SYNC_STAGES+STABLE_CYCLES+1 after `a` changes and holds.
// Backpr. : none; free-running conditioner, every output is registered.
// Ports   : clk, rst_n (async, active-low), bus (debounce_gate_if.slave:
//           a in; out, rise, fall, busy, glitch_cnt out).
// Option  : define DEBOUNCE_GLITCH_CNT_EN to count aborted transitions
//           (saturating at 255); otherwise glitch_cnt is tied to zero.
module debounce_gate #(
  parameter int SYNC_STAGES   = 2,   // 2..4
  parameter int STABLE_CYCLES = 16,  // 2..2^CNT_W
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_gate_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  // ---------------------------------------------------------------
  // Synchroniser: shift `a` through SYNC_STAGES flops; only the last
  // stage is ever looked at by the FSM.
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Debounce FSM with registered outputs.
  // ---------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Edge pulses last exactly one cycle unless re-asserted below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            // Bounced back before qualifying: drop the candidate.
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

  // ---------------------------------------------------------------
  // Optional abort counter. An abort is exactly the WAIT->IDLE bounce
  // taken by the FSM above on this edge.
  // ---------------------------------------------------------------
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       abort;
  logic [7:0] glitch_q;

  assign abort = ((state_q == WAIT_HIGH) && !s) || ((state_q == WAIT_LOW) && s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign bus.glitch_cnt = glitch_q;
`else
  assign bus.glitch_cnt = 8'd0;
`endif

endmodule
